hazard_scoreboard: RTL and testbench

- Parametrised successor to the RV32I pipeline hazard unit.
- Adds a register scoreboard for long-latency (mul/div) writebacks, with up to LONG_DEPTH ops in flight.
- Adds WAW protection, memory wait-state stalls and per-stage stall/flush control.
- Sits beside the 5-stage datapath; drives all pipeline-register enables/clears and the EX operand forwarding muxes.

---
 rtl/hazard_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with long-latency register scoreboard, WAW and memory wait-state stalls.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
  parameter int          REG_AW     = 5,
  parameter int          LONG_DEPTH = 2,
  parameter logic [2:0]  LOAD_CODE  = 3'b001
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              LongOpD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [2:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              LongDoneW,
  input  logic [REG_AW-1:0] LongRdW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              LongBusy,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  localparam int                NREG    = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] X0_C    = {REG_AW{1'b0}};
  localparam logic [2:0]        DEPTH_C = 3'(LONG_DEPTH);

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_nxt_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [2:0]      count_r;
  logic [2:0]      count_nxt_s;
  logic            long_busy_r;
  logic            mem_stall_s;
  logic            lw_stall_s;
  logic            sb_stall_s;
  logic            cap_stall_s;
  logic            decode_stall_s;
  logic            issue_s;
  logic            done_s;
  logic            dec_ok_s;

  function automatic logic reg_pending(input logic [NREG-1:0] p, input logic [REG_AW-1:0] a);
    return (a != X0_C) & p[a];
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rdm, input logic rwm,
                                         input logic [REG_AW-1:0] rdw, input logic rww);
    if (rwm && (rdm != X0_C) && (rdm == rs)) begin
      return 2'b10;
    end else if (rww && (rdw != X0_C) && (rdw == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign mem_stall_s    = MemReqM & ~MemReadyM;
  assign lw_stall_s     = (ResultSrcE == LOAD_CODE) & (RdE != X0_C) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign sb_stall_s     = reg_pending(pending_r, Rs1D) | reg_pending(pending_r, Rs2D)
                        | (RegWriteD & reg_pending(pending_r, RdD));
  assign cap_stall_s    = LongOpD & (count_r == DEPTH_C);
  assign decode_stall_s = lw_stall_s | sb_stall_s | cap_stall_s;

  // Scoreboard updates freeze during a memory wait state; a redirect also cancels the decode op.
  assign issue_s  = LongOpD & ~decode_stall_s & ~mem_stall_s & ~PCSrcE & RST;
  assign done_s   = LongDoneW & ~mem_stall_s;
  assign dec_ok_s = done_s & (count_r != 3'd0);

  assign StallF = RST & (mem_stall_s | decode_stall_s);
  assign StallD = RST & (mem_stall_s | decode_stall_s);
  assign StallE = RST & mem_stall_s;
  assign StallM = RST & mem_stall_s;
  assign FlushD = (PCSrcE & ~mem_stall_s) | ~RST;
  assign FlushE = ((PCSrcE | decode_stall_s) & ~mem_stall_s) | ~RST;
  assign FlushW = mem_stall_s | ~RST;

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  assign LongBusy  = long_busy_r;

  // Next scoreboard state; a same-cycle set of a register overrides its clear.
  always_comb begin
    set_mask_s  = {NREG{1'b0}};
    clr_mask_s  = {NREG{1'b0}};
    count_nxt_s = count_r;
    if (issue_s && RegWriteD && (RdD != X0_C)) begin
      set_mask_s[RdD] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (done_s) begin
      clr_mask_s[LongRdW] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    if (issue_s && !dec_ok_s) begin
      count_nxt_s = count_r + 3'd1;
    end else if (!issue_s && dec_ok_s) begin
      count_nxt_s = count_r - 3'd1;
    end else begin
      count_nxt_s = count_r;
    end
    pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pending_r   <= {NREG{1'b0}};
      count_r     <= 3'd0;
      long_busy_r <= 1'b0;
    end else begin
      pending_r   <= pending_nxt_s;
      count_r     <= count_nxt_s;
      long_busy_r <= (count_nxt_s == DEPTH_C);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating performance counters for stalled fetch cycles and decode flushes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (StallF && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (FlushD && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign StallCnt = stall_cnt_r;
  assign FlushCnt = flush_cnt_r;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expectations, a negedge monitor compares.
module tb_hazard_scoreboard;

  logic       CLK, RST;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
  logic       RegWriteD, LongOpD, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW, LongDoneW;
  logic [2:0] ResultSrcE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, LongBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCnt, FlushCnt;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,LongBusy}
  localparam logic [11:0] IDLE   = 12'h000;
  localparam logic [11:0] DSTALL = 12'hC40;
  localparam logic [11:0] RSTF   = 12'h0E0;
  localparam logic [11:0] MEMST  = 12'hF20;
  localparam logic [11:0] MEMREL = 12'h0C0;
  localparam logic [11:0] BUSY   = 12'h001;

  typedef struct {
    string       name;
    logic [11:0] vec;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [11:0] act;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  hazard_scoreboard dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW), .LongDoneW(LongDoneW), .LongRdW(LongRdW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LongBusy(LongBusy),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clr_in();
    Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; RegWriteD = 1'b0; LongOpD = 1'b0;
    Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; ResultSrcE = 3'd0; PCSrcE = 1'b0;
    RdM = 5'd0; RegWriteM = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    RdW = 5'd0; RegWriteW = 1'b0; LongDoneW = 1'b0; LongRdW = 5'd0;
  endtask

  // Queue the expectation for the current input set, then advance one clock.
  task automatic step(input string nm, input logic [11:0] v);
    exp_t e;
    e.name = nm;
    e.vec  = v;
    e.scnt = PERF ? m_scnt : 32'd0;
    e.fcnt = PERF ? m_fcnt : 32'd0;
    q.push_back(e);
    @(posedge CLK); #1;
    if (!RST) begin
      m_scnt = 32'd0;
      m_fcnt = 32'd0;
    end else begin
      m_scnt = m_scnt + {31'd0, v[11]};
      m_fcnt = m_fcnt + {31'd0, v[7]};
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, LongBusy};
        checks++;
        if (act !== mon_e.vec) begin
          errors++;
          $display("FAIL %s: got %b required %b", mon_e.name, act, mon_e.vec);
        end
        checks++;
        if (StallCnt !== mon_e.scnt || FlushCnt !== mon_e.fcnt) begin
          errors++;
          $display("FAIL %s_cnt: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                   mon_e.name, StallCnt, FlushCnt, mon_e.scnt, mon_e.fcnt);
        end
      end
    end
  end

  initial begin
    clr_in();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    step("reset", RSTF);
    RST = 1'b1;
    step("idle", IDLE);

    // Load-use hazard, forwarding paths
    ResultSrcE = 3'b001; RdE = 5'd5; Rs1D = 5'd5;
    step("lw_stall", DSTALL);
    clr_in(); RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    step("lw_fwd_mem", 12'h010);
    clr_in(); RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd5;
    step("fwd_wb", 12'h002);
    clr_in(); RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
    step("fwd_prio", 12'h014);
    clr_in(); RegWriteM = 1'b1; RegWriteW = 1'b1;
    step("fwd_x0", IDLE);
    clr_in(); ResultSrcE = 3'b001;
    step("lw_x0", IDLE);

    // Long op RAW on x7, then WAW on x9
    clr_in(); LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd7;
    step("long_issue7", IDLE);
    clr_in(); RegWriteD = 1'b1; RdD = 5'd8; Rs1D = 5'd7;
    step("sb_raw", DSTALL);
    step("sb_raw2", DSTALL);
    LongDoneW = 1'b1; LongRdW = 5'd7;
    step("sb_done_cycle", DSTALL);
    LongDoneW = 1'b0;
    step("sb_release", IDLE);
    clr_in(); LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
    step("long_issue9", IDLE);
    clr_in(); RegWriteD = 1'b1; RdD = 5'd9;
    step("waw", DSTALL);
    clr_in(); LongDoneW = 1'b1; LongRdW = 5'd9;
    step("waw_done", IDLE);

    // Capacity limit and simultaneous issue/done
    clr_in(); LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd10;
    step("cap_issue1", IDLE);
    RdD = 5'd11;
    step("cap_issue2", IDLE);
    RdD = 5'd12;
    step("cap_stall", DSTALL | BUSY);
    LongDoneW = 1'b1; LongRdW = 5'd10;
    step("cap_done", DSTALL | BUSY);
    LongDoneW = 1'b0;
    step("cap_release", IDLE);
    clr_in(); LongDoneW = 1'b1; LongRdW = 5'd11;
    step("cap_full_done", BUSY);
    clr_in(); LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd13; LongDoneW = 1'b1; LongRdW = 5'd13;
    step("issue_and_done", IDLE);
    clr_in(); LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd14;
    step("cap_issue3", IDLE);
    clr_in(); Rs1D = 5'd13;
    step("set_wins_full", DSTALL | BUSY);

    // Reset while ops are outstanding
    RST = 1'b0;
    step("reset_mid", RSTF | BUSY);
    RST = 1'b1; Rs2D = 5'd12; RegWriteD = 1'b1; RdD = 5'd14;
    step("post_reset", IDLE);

    // Memory wait states with a pending redirect and a blocked long op
    clr_in(); MemReqM = 1'b1; PCSrcE = 1'b1; LongOpD = 1'b1; RegWriteD = 1'b1; RdD = 5'd20;
    RdM = 5'd3; RegWriteM = 1'b1; Rs1E = 5'd3;
    step("mem_stall1", MEMST | 12'h010);
    step("mem_stall2", MEMST | 12'h010);
    step("mem_stall3", MEMST | 12'h010);
    MemReadyM = 1'b1;
    step("mem_ready_redirect", MEMREL | 12'h010);
    clr_in(); Rs1D = 5'd20; RegWriteD = 1'b1; RdD = 5'd20;
    step("mem_no_issue", IDLE);
    clr_in();
    step("final_idle", IDLE);

    @(posedge CLK); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
